// File: rtl/ws281x_splitter.sv
// WS281X stream decoder and branch demultiplexer.
// Decodes nodes from Din and routes the raw line to one of NUM_BR outputs.
module ws281x_splitter #(
  parameter int NUM_BR = 16,
  parameter int NODE_BITS = 24,
  parameter int SAMPLE_CYC = 30,
  parameter int LATCH_CYC = 2500,
  parameter int MODE = 0,
  parameter logic [NODE_BITS-1:0] ESC_CODE = NODE_BITS'(24'h010203),
  parameter int NODES_PER_BR = 50
) (
  input  logic                      Clock,
  input  logic                      Reset_n,
  input  logic                      Din,
  output logic [NUM_BR-1:0]         BranchOut,
  output logic [$clog2(NUM_BR)-1:0] Branch,
  output logic [NODE_BITS-1:0]      Node,
  output logic                      Valid,
  output logic                      Sync,
  output logic                      Overflow
);

  localparam int TMAX = (SAMPLE_CYC > LATCH_CYC) ? SAMPLE_CYC : LATCH_CYC;
  localparam int TW = $clog2(TMAX + 1);
  localparam int BW = $clog2(NUM_BR);
  localparam int CW = $clog2(NODE_BITS + 1);

  localparam logic [TW-1:0] SAMP = TW'(SAMPLE_CYC);
  localparam logic [TW-1:0] LATCH = TW'(LATCH_CYC);
  localparam logic [CW-1:0] LASTBIT = CW'(NODE_BITS - 1);
  localparam logic [15:0] NPB = 16'(NODES_PER_BR);
  localparam logic [BW-1:0] LASTBR = BW'(NUM_BR - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ACTIVE = 2'd1;
  localparam logic [1:0] S_DISCARD = 2'd2;

  logic s1_q, s2_q, prev_q;
  logic [TW-1:0] bt_q, bt_d;
  logic [TW-1:0] lt_q, lt_d;
  logic armed_q, armed_d;
  logic gap_q, gap_d;
  logic [NODE_BITS-2:0] sh_q, sh_d;
  logic [CW-1:0] bc_q, bc_d;
  logic [NODE_BITS-1:0] node_q, node_d;
  logic valid_q, valid_d;
  logic sync_q, sync_d;
  logic [1:0] state_q, state_d;
  logic [BW-1:0] br_q, br_d;
  logic [15:0] ncnt_q, ncnt_d;
  logic pend_q, pend_d;
  logic [NUM_BR-1:0] bo_q, bo_d;

  logic din_s, rise, at_samp, at_latch, latch;
  logic sample, last_bit, done, adv;
  logic [NODE_BITS-1:0] word;
  logic [15:0] cnt_inc;

  assign din_s = s2_q;
  assign rise = din_s & ~prev_q;
  assign at_samp = (bt_q == SAMP);
  assign at_latch = (lt_q == LATCH);
  assign latch = at_latch & ~gap_q;
  assign sample = armed_q & at_samp;
  assign last_bit = (bc_q == LASTBIT);
  assign word = {sh_q, din_s};
  assign done = sample & last_bit & ~latch;
  assign cnt_inc = ncnt_q + 16'd1;
  assign adv = (MODE == 0) ? (word == ESC_CODE) : (cnt_inc == NPB);

  always_comb begin
    bt_d = rise ? '0 : (at_samp ? bt_q : bt_q + TW'(1));
    lt_d = din_s ? '0 : (at_latch ? lt_q : lt_q + TW'(1));
    gap_d = din_s ? 1'b0 : (gap_q | latch);
    armed_d = armed_q;
    sh_d = sh_q;
    bc_d = bc_q;
    node_d = node_q;
    valid_d = 1'b0;
    sync_d = 1'b0;
    state_d = state_q;
    br_d = br_q;
    ncnt_d = ncnt_q;
    pend_d = pend_q;

    if (sample) begin
      armed_d = 1'b0;
      sh_d = word[NODE_BITS-2:0];
      bc_d = last_bit ? '0 : bc_q + CW'(1);
    end
    if (rise) armed_d = 1'b1;

    // A pending advance switches only at a rising edge, so no pulse is cut.
    if (rise) begin
      if (state_q == S_IDLE) state_d = S_ACTIVE;
      if (pend_q) begin
        pend_d = 1'b0;
        if (br_q == LASTBR) state_d = S_DISCARD;
        else br_d = br_q + BW'(1);
      end
    end

    if (done) begin
      node_d = word;
      valid_d = 1'b1;
      if (MODE != 0) ncnt_d = (cnt_inc == NPB) ? '0 : cnt_inc;
      if (adv) pend_d = 1'b1;
    end

    if (latch) begin
      sync_d = 1'b1;
      bc_d = '0;
      br_d = '0;
      ncnt_d = '0;
      pend_d = 1'b0;
      state_d = S_IDLE;
      if (!rise) armed_d = 1'b0;
    end

    for (int i = 0; i < NUM_BR; i++) begin
      bo_d[i] = din_s & (state_d != S_DISCARD) & (br_d == BW'(i));
    end
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      prev_q <= 1'b0;
      bt_q <= '0;
      lt_q <= '0;
      armed_q <= 1'b0;
      gap_q <= 1'b0;
      sh_q <= '0;
      bc_q <= '0;
      node_q <= '0;
      valid_q <= 1'b0;
      sync_q <= 1'b0;
      state_q <= S_IDLE;
      br_q <= '0;
      ncnt_q <= '0;
      pend_q <= 1'b0;
      bo_q <= '0;
    end else begin
      s1_q <= Din;
      s2_q <= s1_q;
      prev_q <= s2_q;
      bt_q <= bt_d;
      lt_q <= lt_d;
      armed_q <= armed_d;
      gap_q <= gap_d;
      sh_q <= sh_d;
      bc_q <= bc_d;
      node_q <= node_d;
      valid_q <= valid_d;
      sync_q <= sync_d;
      state_q <= state_d;
      br_q <= br_d;
      ncnt_q <= ncnt_d;
      pend_q <= pend_d;
      bo_q <= bo_d;
    end
  end

  assign BranchOut = bo_q;
  assign Branch = br_q;
  assign Node = node_q;
  assign Valid = valid_q;
  assign Sync = sync_q;
  assign Overflow = (state_q == S_DISCARD);

endmodule

// File: tb/tb_ws281x_splitter.sv
// Scoreboard bench for ws281x_splitter: three configurations,
// escape mode, count mode and coincident latch/sample timing.
module tb_ws281x_splitter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [2:0] din = '0;
  logic [2:0][3:0] bo;
  logic [2:0][1:0] br;
  logic [2:0][23:0] nd;
  logic [2:0] vl, sy, ov;

  always #10 clk = ~clk;

  ws281x_splitter #(.NUM_BR(4), .MODE(0)) u0 (
    .Clock(clk), .Reset_n(rst_n), .Din(din[0]),
    .BranchOut(bo[0]), .Branch(br[0]), .Node(nd[0]),
    .Valid(vl[0]), .Sync(sy[0]), .Overflow(ov[0]));

  ws281x_splitter #(.NUM_BR(4), .MODE(1), .NODES_PER_BR(2)) u1 (
    .Clock(clk), .Reset_n(rst_n), .Din(din[1]),
    .BranchOut(bo[1]), .Branch(br[1]), .Node(nd[1]),
    .Valid(vl[1]), .Sync(sy[1]), .Overflow(ov[1]));

  ws281x_splitter #(.NUM_BR(4), .MODE(0),
    .SAMPLE_CYC(30), .LATCH_CYC(30)) u2 (
    .Clock(clk), .Reset_n(rst_n), .Din(din[2]),
    .BranchOut(bo[2]), .Branch(br[2]), .Node(nd[2]),
    .Valid(vl[2]), .Sync(sy[2]), .Overflow(ov[2]));

  typedef struct packed {
    logic s;
    logic [23:0] n;
    logic [1:0] b;
  } ev_t;

  ev_t q[$];
  int n_chk = 0;
  int n_fail = 0;
  int ph = 0;
  logic [2:0] brexp = '0;
  longint last_fall = 0;
  logic h_d [3];
  logic [2:0] h_b [3];
  logic [3:0] ebo;

  task automatic chk(input string nm, input logic [31:0] a,
                     input logic [31:0] e);
    n_chk++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, a, e);
    end
  endtask

  // Line model: BranchOut mirrors Din three edges late on the expected branch.
  always @(posedge clk) begin
    #2;
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) begin
        h_d[i] = 1'b0;
        h_b[i] = '0;
      end
    end else begin
      h_d[2] = h_d[1]; h_b[2] = h_b[1];
      h_d[1] = h_d[0]; h_b[1] = h_b[0];
      h_d[0] = din[ph]; h_b[0] = brexp;
      ebo = (h_d[2] && h_b[2] < 3'd4) ? (4'b0001 << h_b[2]) : 4'b0000;
      chk("branchout", 32'(bo[ph]), 32'(ebo));
      if (vl[ph] || sy[ph]) begin
        if (q.size() == 0) begin
          chk("unexpected_event", {30'd0, vl[ph], sy[ph]}, 32'd0);
        end else begin
          ev_t e;
          e = q.pop_front();
          if (e.s) begin
            chk("sync_evt", {30'd0, vl[ph], sy[ph]}, 32'd1);
          end else begin
            chk("valid_evt", {30'd0, vl[ph], sy[ph]}, 32'd2);
            chk("node", 32'(nd[ph]), 32'(e.n));
            chk("branch", 32'(br[ph]), 32'(e.b));
          end
        end
      end
    end
  end

  task automatic send_bit(input int k, input logic b);
    int hi, lo;
    if (k == 2) begin
      hi = b ? 32 : 10;
      lo = b ? 8 : 25;
    end else begin
      hi = b ? 40 : 15;
      lo = b ? 20 : 45;
    end
    @(negedge clk) din[k] = 1'b1;
    repeat (hi) @(negedge clk);
    din[k] = 1'b0;
    last_fall = longint'($time);
    repeat (lo - 1) @(negedge clk);
  endtask

  task automatic send_node(input int k, input logic [23:0] v,
                           input logic [2:0] b);
    ev_t e;
    e.s = 1'b0;
    e.n = v;
    e.b = (b > 3'd3) ? 2'd3 : b[1:0];
    q.push_back(e);
    brexp = b;
    for (int i = 23; i >= 0; i--) send_bit(k, v[i]);
  endtask

  task automatic push_sync();
    ev_t e;
    e.s = 1'b1;
    e.n = '0;
    e.b = '0;
    q.push_back(e);
  endtask

  task automatic drain(input string nm, input int lim);
    for (int c = 0; c < lim && q.size() != 0; c++) @(posedge clk);
    repeat (2) @(negedge clk);
    chk(nm, 32'(q.size()), 32'd0);
  endtask

  task automatic do_reset(input int p);
    @(negedge clk);
    rst_n = 1'b0;
    din = '0;
    ph = p;
    brexp = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    repeat (80000) @(posedge clk);
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [11:0] pv;
    logic [23:0] v;
    bit got;
    longint cyc;

    pv = 12'hABC;
    repeat (3) @(negedge clk);
    chk("rst_bo", 32'(bo[0]), 32'd0);
    chk("rst_br", 32'(br[0]), 32'd0);
    chk("rst_node", 32'(nd[0]), 32'd0);
    chk("rst_valid", 32'(vl[0]), 32'd0);
    chk("rst_sync", 32'(sy[0]), 32'd0);
    chk("rst_ovf", 32'(ov[0]), 32'd0);
    rst_n = 1'b1;

    send_node(0, 24'hFF0000, 3'd0);
    send_node(0, 24'h010203, 3'd0);
    send_node(0, 24'h00FF00, 3'd1);
    drain("esc_drain", 200);
    chk("esc_node", 32'(nd[0]), 32'h00FF00);
    chk("esc_branch", 32'(br[0]), 32'd1);

    brexp = 3'd1;
    for (int i = 11; i >= 0; i--) send_bit(0, pv[i]);
    push_sync();
    got = 1'b0;
    cyc = 0;
    for (int c = 0; c < 2700 && !got; c++) begin
      @(posedge clk);
      #3;
      if (sy[0]) begin
        got = 1'b1;
        cyc = (longint'($time) - last_fall) / 20;
      end
    end
    chk("sync_seen", 32'(got), 32'd1);
    chk("sync_delay", 32'(cyc >= 2500 && cyc <= 2504), 32'd1);
    brexp = 3'd0;
    drain("latch_drain", 50);
    chk("latch_branch", 32'(br[0]), 32'd0);
    chk("latch_ovf", 32'(ov[0]), 32'd0);
    chk("latch_node", 32'(nd[0]), 32'h00FF00);

    send_node(0, 24'h0000FF, 3'd0);
    send_node(0, 24'h010203, 3'd0);
    send_node(0, 24'h111111, 3'd1);
    v = 24'hC3C3C3;
    for (int i = 23; i >= 15; i--) send_bit(0, v[i]);
    @(negedge clk) din[0] = 1'b1;
    repeat (20) @(negedge clk);
    rst_n = 1'b0;
    din[0] = 1'b0;
    #1;
    chk("midrst_bo", 32'(bo[0]), 32'd0);
    chk("midrst_br", 32'(br[0]), 32'd0);
    chk("midrst_node", 32'(nd[0]), 32'd0);
    chk("midrst_valid", 32'(vl[0]), 32'd0);
    chk("midrst_ovf", 32'(ov[0]), 32'd0);
    chk("midrst_queue", 32'(q.size()), 32'd0);
    repeat (3) @(negedge clk);
    brexp = 3'd0;
    rst_n = 1'b1;
    send_node(0, 24'h5A5A5A, 3'd0);
    drain("midrst_drain", 200);
    chk("midrst_after", 32'(nd[0]), 32'h5A5A5A);

    do_reset(1);
    for (int n = 0; n < 10; n++) begin
      send_node(1, 24'hC00000 | 24'(n), (n < 8) ? 3'(n / 2) : 3'd4);
    end
    drain("cnt_drain", 200);
    chk("cnt_ovf", 32'(ov[1]), 32'd1);
    chk("cnt_branch", 32'(br[1]), 32'd3);
    push_sync();
    drain("cnt_latch", 3000);
    chk("cnt_ovf_clr", 32'(ov[1]), 32'd0);
    chk("cnt_branch_clr", 32'(br[1]), 32'd0);

    do_reset(2);
    push_sync();
    drain("short_idle", 100);
    send_node(2, 24'h123456, 3'd0);
    v = 24'h0F0F0F;
    for (int i = 23; i >= 1; i--) send_bit(2, v[i]);
    push_sync();
    @(negedge clk) din[2] = 1'b1;
    @(negedge clk) din[2] = 1'b0;
    drain("coinc_drain", 150);
    chk("coinc_branch", 32'(br[2]), 32'd0);
    chk("coinc_node", 32'(nd[2]), 32'h123456);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
